// File: rtl/alu_pkg.sv
// Shared definitions for the ALU op sequencer slice.
// Holds the ALU operation codes, the MIPS-style opcode/funct field values
// recognised by the decoder, the sequencer state enum and a small helper
// classifying multi-cycle operations.
package alu_pkg;

    // ALU operation codes; zero-extended to FUNC_W at the decoder output.
    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_SUB     = 4'd1;
    localparam logic [3:0] ALU_AND     = 4'd2;
    localparam logic [3:0] ALU_OR      = 4'd3;
    localparam logic [3:0] ALU_XOR     = 4'd4;
    localparam logic [3:0] ALU_NOR     = 4'd5;
    localparam logic [3:0] ALU_SLL     = 4'd6;
    localparam logic [3:0] ALU_SRL     = 4'd7;
    localparam logic [3:0] ALU_SLT     = 4'd8;
    localparam logic [3:0] ALU_MULSTEP = 4'd9;
    localparam logic [3:0] ALU_DIVSTEP = 4'd10;

    // Opcode field values.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // R-type funct field values.
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_ITER   = 2'd2
    } seq_state_e;

    // Multiply/divide steps are the only operations spanning DATA_W beats.
    function automatic logic is_multi_cycle(input logic [3:0] code);
        return (code == ALU_MULSTEP) || (code == ALU_DIVSTEP);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction-in / ALU-beat-out handshake bundle for alu_op_sequencer.
// Signals:
//   in_valid/in_ready/opcode/funct          - instruction acceptance channel
//   out_valid/out_ready/alu_func/out_last/
//   iter_idx/illegal                        - ALU operation beat channel
// Modports:
//   master - environment side (issues instructions, consumes beats)
//   slave  - sequencer side
interface alu_op_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int FUNC_W = 4
) ();
    localparam int IDX_W = $clog2(DATA_W);

    logic              in_valid;
    logic              in_ready;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic              out_valid;
    logic              out_ready;
    logic [FUNC_W-1:0] alu_func;
    logic              out_last;
    logic [IDX_W-1:0]  iter_idx;
    logic              illegal;

    modport master (
        output in_valid, opcode, funct, out_ready,
        input  in_ready, out_valid, alu_func, out_last, iter_idx, illegal
    );

    modport slave (
        input  in_valid, opcode, funct, out_ready,
        output in_ready, out_valid, alu_func, out_last, iter_idx, illegal
    );
endinterface

// File: rtl/alu_decode.sv
// Purely combinational opcode/funct decoder.
// Ports:
//   opcode, funct  - instruction fields
//   code           - ALU operation code, all ones when undecodable
//   multi_cycle    - operation runs as a DATA_W-beat iteration
//   illegal        - opcode/funct combination is not recognised
module alu_decode
    import alu_pkg::*;
#(
    parameter int FUNC_W = 4
) (
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    output logic [FUNC_W-1:0] code,
    output logic              multi_cycle,
    output logic              illegal
);

    logic [3:0] base_code_s;
    logic       bad_s;

    // Two-level decode: opcode first, funct only for R-type.
    always_comb begin
        base_code_s = ALU_ADD;
        bad_s       = 1'b0;
        case (opcode)
            OP_ADDI, OP_LH, OP_LW, OP_SW: base_code_s = ALU_ADD;
            OP_BEQ:                       base_code_s = ALU_SUB;
            OP_SLTI:                      base_code_s = ALU_SLT;
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  base_code_s = ALU_ADD;
                    FN_SUB:  base_code_s = ALU_SUB;
                    FN_AND:  base_code_s = ALU_AND;
                    FN_OR:   base_code_s = ALU_OR;
                    FN_XOR:  base_code_s = ALU_XOR;
                    FN_NOR:  base_code_s = ALU_NOR;
                    FN_SLL:  base_code_s = ALU_SLL;
                    FN_SRL:  base_code_s = ALU_SRL;
                    FN_SLT:  base_code_s = ALU_SLT;
                    FN_MULT: base_code_s = ALU_MULSTEP;
                    FN_DIV:  base_code_s = ALU_DIVSTEP;
                    default: bad_s       = 1'b1;
                endcase
            end
            default: bad_s = 1'b1;
        endcase
    end

    // Invalid instructions map to the all-ones code and are never multi-cycle.
    always_comb begin
        if (bad_s) begin
            code        = {FUNC_W{1'b1}};
            multi_cycle = 1'b0;
        end else begin
            code        = FUNC_W'(base_code_s);
            multi_cycle = is_multi_cycle(base_code_s);
        end
        illegal = bad_s;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Turns one accepted instruction into a stream of registered ALU beats:
// a single beat for ordinary and invalid instructions, DATA_W beats for
// multiply/divide steps. A new instruction is accepted only when idle, so
// every instruction is followed by one bubble cycle.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - alu_op_sequencer_if slave modport (instruction in, beats out)
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FUNC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_op_sequencer_if.slave bus
);

    localparam int               IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    seq_state_e        state_r,     state_s;
    logic              in_ready_r,  in_ready_s;
    logic              out_valid_r, out_valid_s;
    logic [FUNC_W-1:0] alu_func_r,  alu_func_s;
    logic              out_last_r,  out_last_s;
    logic [IDX_W-1:0]  iter_idx_r,  iter_idx_s;
    logic              illegal_r,   illegal_s;

    logic [FUNC_W-1:0] dec_code_s;
    logic              dec_multi_s;
    logic              dec_illegal_s;
    logic [IDX_W-1:0]  idx_inc_s;

    alu_decode #(.FUNC_W(FUNC_W)) u_decode (
        .opcode      (bus.opcode),
        .funct       (bus.funct),
        .code        (dec_code_s),
        .multi_cycle (dec_multi_s),
        .illegal     (dec_illegal_s)
    );

    assign idx_inc_s = iter_idx_r + IDX_W'(1'b1);

    // Next-state and next-output logic; all outputs come straight from registers.
    always_comb begin
        state_s     = state_r;
        out_valid_s = out_valid_r;
        alu_func_s  = alu_func_r;
        out_last_s  = out_last_r;
        iter_idx_s  = iter_idx_r;
        illegal_s   = illegal_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    state_s     = dec_multi_s ? ST_ITER : ST_SINGLE;
                    out_valid_s = 1'b1;
                    alu_func_s  = dec_code_s;
                    out_last_s  = ~dec_multi_s;
                    iter_idx_s  = '0;
                    illegal_s   = dec_illegal_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SINGLE: begin
                if (bus.out_ready) begin
                    state_s     = ST_IDLE;
                    out_valid_s = 1'b0;
                    alu_func_s  = '0;
                    out_last_s  = 1'b0;
                    iter_idx_s  = '0;
                    illegal_s   = 1'b0;
                end else begin
                    state_s = ST_SINGLE;
                end
            end
            ST_ITER: begin
                if (bus.out_ready) begin
                    if (iter_idx_r == LAST_IDX) begin
                        state_s     = ST_IDLE;
                        out_valid_s = 1'b0;
                        alu_func_s  = '0;
                        out_last_s  = 1'b0;
                        iter_idx_s  = '0;
                        illegal_s   = 1'b0;
                    end else begin
                        iter_idx_s = idx_inc_s;
                        out_last_s = (idx_inc_s == LAST_IDX);
                    end
                end else begin
                    state_s = ST_ITER;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                out_valid_s = 1'b0;
                alu_func_s  = '0;
                out_last_s  = 1'b0;
                iter_idx_s  = '0;
                illegal_s   = 1'b0;
            end
        endcase
        // Ready is registered too, so it reflects the state being entered.
        in_ready_s = (state_s == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            alu_func_r  <= '0;
            out_last_r  <= 1'b0;
            iter_idx_r  <= '0;
            illegal_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            alu_func_r  <= alu_func_s;
            out_last_r  <= out_last_s;
            iter_idx_r  <= iter_idx_s;
            illegal_r   <= illegal_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.alu_func  = alu_func_r;
    assign bus.out_last  = out_last_r;
    assign bus.iter_idx  = iter_idx_r;
    assign bus.illegal   = illegal_r;

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter DATA_W, default 32, operand width; sets the iteration count of multi-cycle ops; legal range 8..64.
REQ-002 Parameter FUNC_W, default 4, width of alu_func; minimum 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  opcode/funct valid.
REQ-006 in_ready  output  1  sequencer can accept a new instruction.
REQ-007 opcode  input  6  instruction opcode field.
REQ-008 funct  input  6  R-type function field.
REQ-009 out_valid  output  1  alu_func beat valid.
REQ-010 out_ready  input  1  datapath consumes the current beat.
REQ-011 alu_func  output  FUNC_W  registered ALU operation code.
REQ-012 out_last  output  1  current beat is the final beat of the instruction.
REQ-013 iter_idx  output  clog2(DATA_W)  beat index within a multi-cycle op; 0 for single-beat ops.
REQ-014 illegal  output  1  current beat comes from an undecodable opcode/funct.

Function
REQ-015 Codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLL=6, SRL=7, SLT=8, MULSTEP=9, DIVSTEP=10, INVALID=all ones; codes zero-extended to FUNC_W.
REQ-016 Opcode decode: 001000 addi, 100001 lh, 100011 lw, 101011 sw -> ADD; 000100 beq -> SUB; 001010 slti -> SLT; 000000 -> funct decode; any other opcode -> INVALID.
REQ-017 Funct decode: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000000 SLL, 000010 SRL, 101010 SLT, 011000 MULSTEP, 011010 DIVSTEP; any other funct -> INVALID.
REQ-018 States: IDLE, SINGLE, ITER.
REQ-019 in_ready is 1 only in IDLE; handshake occurs on in_valid & in_ready at a rising edge.
REQ-020 On handshake: INVALID or single-cycle code -> SINGLE; MULSTEP/DIVSTEP -> ITER with iter_idx=0.
REQ-021 Latency: out_valid goes 1 in the cycle after the handshake; no combinational path from in_valid to out_valid.
REQ-022 SINGLE: one beat; out_last=1, iter_idx=0; illegal=1 only for INVALID.
REQ-023 ITER: DATA_W beats with identical alu_func; iter_idx 0..DATA_W-1; out_last=1 only at iter_idx=DATA_W-1.
REQ-024 iter_idx advances only when out_valid & out_ready; no wrap-around.
REQ-025 alu_func, iter_idx, out_last and illegal stay stable while out_valid=1 and out_ready=0.
REQ-026 On acceptance of a beat with out_last=1: IDLE next cycle, out_valid=0, in_ready=1; no same-cycle re-accept (one bubble per instruction).
REQ-027 in_valid, opcode and funct are ignored outside IDLE; the decoded instruction is captured at the handshake.

Reset
REQ-028 rst_n=0 immediately forces IDLE: in_ready=1, out_valid=0, alu_func=0, out_last=0, iter_idx=0, illegal=0.
REQ-029 Reset during SINGLE or ITER aborts the instruction; no further beats are emitted and there is no resumption.
REQ-030 Registers are released on the first rising clk with rst_n=1; no output change occurs before that edge.

Structure
REQ-031 Shared package alu_pkg holds the ALU code constants, opcode/funct constants and the state enum.
REQ-032 Sub-module alu_decode: purely combinational opcode/funct -> {code, multi_cycle, illegal}; alu_op_sequencer owns the FSM, counter and output registers.

Verification
REQ-033 addi (opcode 001000), out_ready=1 -> one beat alu_func=0, out_last=1, illegal=0; in_ready=1 two cycles after the handshake.
REQ-034 R-type funct 100111, out_ready held 0 for 3 cycles -> alu_func=5 stable for 4 cycles; beat is consumed on cycle 4.
REQ-035 mult (funct 011000), DATA_W=8, out_ready=1 -> 8 beats alu_func=9, iter_idx 0..7, out_last only on beat 7.
REQ-036 opcode 111111 -> one beat alu_func=INVALID (15 for FUNC_W=4), illegal=1, out_last=1.
REQ-037 div with DATA_W=32; rst_n=0 at iter_idx=5 -> out_valid=0 and in_ready=1 immediately; no further beats after release.
REQ-038 Back-to-back valid instructions -> second handshake exactly one cycle after the first instruction's last beat is accepted.
